nested_struct_decoder: RTL and testbench

- Receive end for 62-bit nested-struct records produced by the upstream field-transform stage, which applies addr+1, data^KEY, id+ID_INC, cmd|4'b1010, valid&=ready, ready=valid.
- Undoes the reversible fields, checks the encoding invariants, flags violations and buffers decoded records in a small FIFO.
- Valid/ready handshake on both sides, so the block can sit between the transform stage and a stalling consumer.

---
 rtl/nested_struct_decoder.sv | 103 ++++++++++
 tb/tb_nested_struct_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nested_struct_decoder.sv
// Receive end of the nested-struct field transform: undoes the reversible fields,
// flags broken encoding invariants and buffers decoded records in a small FIFO.
module nested_struct_decoder #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] KEY      = 32'hDEADBEEF,
   parameter logic [7:0]  ADDR_INC = 8'd1,
   parameter logic [15:0] ID_INC   = 16'd100
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [61:0]              in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [61:0]              out_data,
   output logic                     out_err,
   output logic [15:0]              err_count,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        valid;
   } base_t;

   typedef struct packed {
      base_t       base;
      logic [15:0] id;
      logic [3:0]  cmd;
      logic        ready;
   } rec_t;

   rec_t           encRec;
   rec_t           decRec;
   logic           decErr;
   logic [62:0]    mem [DEPTH];
   logic [62:0]    headEntry;
   logic [AW-1:0]  wrPtr;
   logic [AW-1:0]  rdPtr;
   logic           push;
   logic           pop;

   assign encRec = in_data;

   // Upstream ORs 4'b1010 into cmd and overwrites ready with valid, so those bits
   // carry no information: clear them and rebuild ready from base.valid.
   always_comb begin
      decRec            = encRec;
      decRec.base.addr  = encRec.base.addr - ADDR_INC;
      decRec.base.data  = encRec.base.data ^ KEY;
      decRec.id         = encRec.id - ID_INC;
      decRec.cmd        = {1'b0, encRec.cmd[2], 1'b0, encRec.cmd[0]};
      decRec.ready      = encRec.base.valid;
      decErr            = !encRec.cmd[3] || !encRec.cmd[1] ||
                          (encRec.base.valid && !encRec.ready);
   end

   assign in_ready  = (level != LW'(DEPTH));
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Head is forced to zero while empty so reset visibly clears the outputs.
   assign headEntry = mem[rdPtr];
   assign out_data  = out_valid ? headEntry[61:0] : '0;
   assign out_err   = out_valid ? headEntry[62]   : 1'b0;

   always_ff @(posedge clk) begin
      if (push && rst_n) begin
         mem[wrPtr] <= {decErr, decRec};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         level     <= '0;
         err_count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
         if (push && decErr && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_nested_struct_decoder.sv
// Directed bench for nested_struct_decoder: decode, wrap-around, error flags,
// backpressure, concurrent push/pop and mid-stream reset.
module tb_nested_struct_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [61:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [61:0] out_data;
   logic        out_err;
   logic [15:0] err_count;
   logic [2:0]  level;

   int testsRun    = 0;
   int testsFailed = 0;

   nested_struct_decoder #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .err_count (err_count),
      .level     (level)
   );

   always #5 clk = ~clk;

   function automatic logic [61:0] mkRec(input logic [7:0] a, input logic [31:0] d,
                                         input logic v, input logic [15:0] id,
                                         input logic [3:0] c, input logic r);
      return {a, d, v, id, c, r};
   endfunction

   // Well-formed record i: enc addr 0x21+i, data DEADBEE0|i, id 100+i, cmd F, valid/ready 1.
   function automatic logic [61:0] goodEnc(input int i);
      return mkRec(8'h21 + 8'(i), 32'hDEADBEE0 | 32'(i), 1'b1, 16'd100 + 16'(i), 4'hF, 1'b1);
   endfunction

   function automatic logic [61:0] goodDec(input int i);
      return mkRec(8'h20 + 8'(i), 32'h0000000F ^ 32'(i), 1'b1, 16'(i), 4'h5, 1'b1);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle push; outputs are sampled 1ns after the accepting edge.
   task automatic applyStimulus(input logic [61:0] rec);
      in_valid = 1'b1;
      in_data  = rec;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic sendAndCheck(input string tag, input logic [61:0] enc,
                               input logic [61:0] expData, input logic expErr);
      applyStimulus(enc);
      checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_data"},  64'(out_data),  64'(expData));
      checkOutput({tag, "_err"},   64'(out_err),   64'(expErr));
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      checkOutput("rst_level",    64'(level),     64'd0);
      checkOutput("rst_out_valid",64'(out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready),  64'd1);
      checkOutput("rst_err_count",64'(err_count), 64'd0);
      checkOutput("rst_out_data", 64'(out_data),  64'd0);

      sendAndCheck("basic", mkRec(8'h11, 32'hCC99E897, 1'b1, 16'h0074, 4'hF, 1'b1),
                   mkRec(8'h10, 32'h12345678, 1'b1, 16'h0010, 4'h5, 1'b1), 1'b0);
      checkOutput("basic_drained", 64'(level), 64'd0);

      sendAndCheck("wrap", mkRec(8'h00, 32'hDEADBEEF, 1'b0, 16'd50, 4'hA, 1'b0),
                   mkRec(8'hFF, 32'h0, 1'b0, 16'd65486, 4'h0, 1'b0), 1'b0);

      sendAndCheck("err_cmd", mkRec(8'h05, 32'hDEADBEEF, 1'b0, 16'd100, 4'h5, 1'b0),
                   mkRec(8'h04, 32'h0, 1'b0, 16'd0, 4'h5, 1'b0), 1'b1);
      sendAndCheck("err_vr", mkRec(8'h05, 32'hDEADBEEF, 1'b1, 16'd100, 4'hA, 1'b0),
                   mkRec(8'h04, 32'h0, 1'b1, 16'd0, 4'h0, 1'b1), 1'b1);
      sendAndCheck("ok_v0r1", mkRec(8'h05, 32'hDEADBEEF, 1'b0, 16'd100, 4'hA, 1'b1),
                   mkRec(8'h04, 32'h0, 1'b0, 16'd0, 4'h0, 1'b0), 1'b0);
      checkOutput("err_count_2", 64'(err_count), 64'd2);

      // Backpressure: four fill the FIFO, the fifth is held until a slot frees.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = goodEnc(i);
         tick();
      end
      in_data = goodEnc(4);
      checkOutput("bp_full_level", 64'(level),    64'd4);
      checkOutput("bp_in_ready",   64'(in_ready), 64'd0);
      tick();
      checkOutput("bp_hold_level", 64'(level),    64'd4);
      out_ready = 1'b1;
      checkOutput("bp_head0", 64'(out_data), 64'(goodDec(0)));
      tick();
      checkOutput("bp_level_after_pop", 64'(level),    64'd3);
      checkOutput("bp_ready_after_pop", 64'(in_ready), 64'd1);
      checkOutput("bp_head1", 64'(out_data), 64'(goodDec(1)));
      tick();
      in_valid = 1'b0;
      checkOutput("bp_fifth_accepted", 64'(level), 64'd3);
      for (int i = 2; i < 5; i++) begin
         checkOutput($sformatf("bp_head%0d", i), 64'(out_data), 64'(goodDec(i)));
         tick();
      end
      checkOutput("bp_empty", 64'(out_valid), 64'd0);

      // Concurrent push/pop at level 2.
      out_ready = 1'b0;
      applyStimulus(goodEnc(10));
      applyStimulus(goodEnc(11));
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_data = goodEnc(12 + k);
         checkOutput($sformatf("cc_level%0d", k), 64'(level),    64'd2);
         checkOutput($sformatf("cc_head%0d", k),  64'(out_data), 64'(goodDec(10 + k)));
         tick();
      end
      in_valid = 1'b0;
      checkOutput("cc_level_end", 64'(level),    64'd2);
      checkOutput("cc_head_end",  64'(out_data), 64'(goodDec(20)));
      tick();
      tick();
      checkOutput("cc_drained", 64'(level), 64'd0);

      // Build err_count=7 and level=3, then reset with a record on the input.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(mkRec(8'h01, 32'h0, 1'b1, 16'd0, 4'hA, 1'b0));
      end
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(goodEnc(i));
      end
      checkOutput("pre_rst_err_count", 64'(err_count), 64'd7);
      checkOutput("pre_rst_level",     64'(level),     64'd3);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = mkRec(8'h01, 32'h0, 1'b1, 16'd0, 4'h0, 1'b0);
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      checkOutput("mid_rst_level",     64'(level),     64'd0);
      checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("mid_rst_err_count", 64'(err_count), 64'd0);
      checkOutput("mid_rst_out_data",  64'(out_data),  64'd0);
      checkOutput("mid_rst_out_err",   64'(out_err),   64'd0);
      tick();
      checkOutput("mid_rst_not_stored", 64'(level), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
